// File: rtl/demux_1to4_reg.sv
// rtl/demux_1to4_reg.sv - registered 1-to-4 write demux with per-slot valid and overwrite tracking
module demux_1to4_reg #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     data_i,
    input  logic [1:0]           selector,
    input  logic                 wr_en,
    input  logic [3:0]           rd_ack,
    output logic [WIDTH-1:0]     data_1,
    output logic [WIDTH-1:0]     data_2,
    output logic [WIDTH-1:0]     data_3,
    output logic [WIDTH-1:0]     data_4,
    output logic [3:0]           valid_o,
    output logic                 overwrite_o,
    output logic [CNT_WIDTH-1:0] overwrite_cnt
);

    logic [3:0]           wr_onehot;
    logic                 overwrite_hit;
    logic [3:0]           valid_next;

    always_comb begin
        wr_onehot = 4'b0000;
        if (wr_en) begin
            wr_onehot[selector] = 1'b1;
        end
        // An ack in the same edge as the write counts as consumption, so no loss
        overwrite_hit = |(wr_onehot & valid_o & ~rd_ack);
        valid_next    = (valid_o & ~rd_ack) | wr_onehot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_1        <= '0;
            data_2        <= '0;
            data_3        <= '0;
            data_4        <= '0;
            valid_o       <= 4'b0000;
            overwrite_o   <= 1'b0;
            overwrite_cnt <= '0;
        end else begin
            if (wr_onehot[0]) data_1 <= data_i;
            if (wr_onehot[1]) data_2 <= data_i;
            if (wr_onehot[2]) data_3 <= data_i;
            if (wr_onehot[3]) data_4 <= data_i;
            valid_o     <= valid_next;
            overwrite_o <= overwrite_hit;
            if (overwrite_hit && (overwrite_cnt != {CNT_WIDTH{1'b1}})) begin
                overwrite_cnt <= overwrite_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_1to4_reg.sv
// tb/tb_demux_1to4_reg.sv - directed self-checking bench for demux_1to4_reg
module tb_demux_1to4_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_i;
    logic [1:0]  selector;
    logic        wr_en;
    logic [3:0]  rd_ack;
    logic [31:0] data_1, data_2, data_3, data_4;
    logic [3:0]  valid_o;
    logic        overwrite_o;
    logic [7:0]  overwrite_cnt;

    int checks = 0;
    int errors = 0;

    demux_1to4_reg #(.WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_i        (data_i),
        .selector      (selector),
        .wr_en         (wr_en),
        .rd_ack        (rd_ack),
        .data_1        (data_1),
        .data_2        (data_2),
        .data_3        (data_3),
        .data_4        (data_4),
        .valid_o       (valid_o),
        .overwrite_o   (overwrite_o),
        .overwrite_cnt (overwrite_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock one edge, then sample 1 time unit after the edge
    task automatic step(input logic rst, input logic we, input logic [1:0] sel,
                        input logic [31:0] d, input logic [3:0] ack);
        reset    = rst;
        wr_en    = we;
        selector = sel;
        data_i   = d;
        rd_ack   = ack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;
        step(1'b1, 1'b1, 2'b00, 32'hDEAD_BEEF, 4'b0000);
        step(1'b1, 1'b1, 2'b00, 32'hDEAD_BEEF, 4'b0000);
        check("rst_data_1", data_1, 0);
        check("rst_data_2", data_2, 0);
        check("rst_data_3", data_3, 0);
        check("rst_data_4", data_4, 0);
        check("rst_valid", valid_o, 4'b0000);
        check("rst_ov", overwrite_o, 0);
        check("rst_cnt", overwrite_cnt, 0);

        step(1'b0, 1'b1, 2'b00, 32'h11, 4'b0000);
        check("first_write_valid", valid_o, 4'b0001);
        step(1'b0, 1'b1, 2'b01, 32'h22, 4'b0000);
        step(1'b0, 1'b1, 2'b10, 32'h33, 4'b0000);
        step(1'b0, 1'b1, 2'b11, 32'h44, 4'b0000);
        check("fill_data_1", data_1, 32'h11);
        check("fill_data_2", data_2, 32'h22);
        check("fill_data_3", data_3, 32'h33);
        check("fill_data_4", data_4, 32'h44);
        check("fill_valid", valid_o, 4'b1111);
        check("fill_ov", overwrite_o, 0);

        step(1'b0, 1'b0, 2'b00, 32'h0, 4'b0101);
        check("ack_valid", valid_o, 4'b1010);
        check("ack_data_1", data_1, 32'h11);
        check("ack_data_3", data_3, 32'h33);

        step(1'b0, 1'b1, 2'b10, 32'hA, 4'b0000);
        check("wr_invalid_slot_ov", overwrite_o, 0);
        check("wr_invalid_slot_valid", valid_o, 4'b1110);
        step(1'b0, 1'b1, 2'b10, 32'hB, 4'b0000);
        check("ovw_data_3", data_3, 32'hB);
        check("ovw_pulse", overwrite_o, 1);
        check("ovw_cnt", overwrite_cnt, 1);
        step(1'b0, 1'b0, 2'b00, 32'h0, 4'b0000);
        check("ovw_pulse_end", overwrite_o, 0);
        check("ovw_cnt_hold", overwrite_cnt, 1);

        step(1'b0, 1'b1, 2'b01, 32'h55, 4'b0010);
        check("coll_data_2", data_2, 32'h55);
        check("coll_valid", valid_o, 4'b1110);
        check("coll_ov", overwrite_o, 0);
        check("coll_cnt", overwrite_cnt, 1);

        step(1'b0, 1'b0, 2'b00, 32'h0, 4'b0001);
        check("ack_invalid_valid", valid_o, 4'b1110);
        check("ack_invalid_data_1", data_1, 32'h11);

        step(1'b0, 1'b1, 2'b00, 32'h66, 4'b1000);
        check("wr_ack_other_valid", valid_o, 4'b0111);
        check("wr_ack_other_data_1", data_1, 32'h66);
        check("wr_ack_other_ov", overwrite_o, 0);

        exp_cnt = 1;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 2'b00, 32'h1000 + i, 4'b0000);
            if (exp_cnt < 255) exp_cnt++;
            check("sat_ov", overwrite_o, 1);
            check("sat_cnt", overwrite_cnt, exp_cnt);
        end
        check("sat_cnt_final", overwrite_cnt, 255);
        check("sat_data_1", data_1, 32'h1000 + 299);

        step(1'b1, 1'b0, 2'b00, 32'h0, 4'b0000);
        check("rst2_cnt", overwrite_cnt, 0);
        step(1'b0, 1'b1, 2'b00, 32'h1, 4'b0000);
        step(1'b0, 1'b1, 2'b01, 32'h2, 4'b0000);
        step(1'b0, 1'b1, 2'b10, 32'h3, 4'b0000);
        step(1'b0, 1'b1, 2'b11, 32'h4, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 2'b00, 32'h70 + i, 4'b0000);
        end
        check("pre_rst_valid", valid_o, 4'b1111);
        check("pre_rst_cnt", overwrite_cnt, 5);
        check("pre_rst_ov", overwrite_o, 1);

        step(1'b1, 1'b1, 2'b10, 32'h99, 4'b0000);
        check("midrst_data_1", data_1, 0);
        check("midrst_data_3", data_3, 0);
        check("midrst_valid", valid_o, 4'b0000);
        check("midrst_ov", overwrite_o, 0);
        check("midrst_cnt", overwrite_cnt, 0);

        step(1'b0, 1'b1, 2'b11, 32'h77, 4'b0000);
        check("post_rst_data_4", data_4, 32'h77);
        check("post_rst_valid", valid_o, 4'b1000);
        check("post_rst_data_3", data_3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
